// File: rtl/cselsub_pkg.sv
// Shared definitions for the carry-select subtractor pipeline.
// Saturating output is enabled at build time with CSELSUB_SAT_EN.
package cselsub_pkg;

  localparam int SLICE_DEF = 16;

  // Result of one slice subtraction: borrow-out plus the slice difference.
  typedef struct packed {
    logic                 bout;
    logic [SLICE_DEF-1:0] d;
  } slice_res_t;

  localparam logic [2*SLICE_DEF-1:0] SAT_POS = {1'b0, {(2*SLICE_DEF-1){1'b1}}};
  localparam logic [2*SLICE_DEF-1:0] SAT_NEG = {1'b1, {(2*SLICE_DEF-1){1'b0}}};

endpackage

// File: rtl/sub_slice.sv
// SLICE-bit unsigned subtractor with borrow-in and borrow-out.
// The borrow-out is the top bit of the (SLICE+1)-bit difference.
module sub_slice #(
  parameter int SLICE = 16
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             bin,
  output logic [SLICE-1:0] d,
  output logic             bout
);

  logic [SLICE:0] w_res;

  assign w_res = {1'b0, a} - {1'b0, b} - {{SLICE{1'b0}}, bin};
  assign d     = w_res[SLICE-1:0];
  assign bout  = w_res[SLICE];

endmodule

// File: rtl/cselsub_pipe.sv
// Two-stage carry-select subtractor (diff = a - b) behind valid/ready handshakes.
// Define CSELSUB_SAT_EN to saturate diff on signed overflow.
module cselsub_pipe
  import cselsub_pkg::*;
#(
  parameter int SLICE = SLICE_DEF
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*SLICE-1:0] a,
  input  logic [2*SLICE-1:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*SLICE-1:0] diff,
  output logic               borrow,
  output logic               overflow
);

  localparam int WIDTH = 2 * SLICE;

  logic               w_lo_b;
  logic [SLICE-1:0]   w_lo_d;
  logic [1:0]         w_hi_b;
  logic [1:0][SLICE-1:0] w_hi_d;

  logic               r_s1_valid;
  logic [SLICE-1:0]   r_lo;
  logic               r_bl;
  logic [SLICE-1:0]   r_hi0;
  logic [SLICE-1:0]   r_hi1;
  logic               r_bh0;
  logic               r_bh1;
  logic               r_sa;
  logic               r_sb;

  logic               r_out_valid;
  logic [WIDTH-1:0]   r_diff;
  logic               r_borrow;
  logic               r_overflow;

  logic               w_s2_adv;
  logic               w_accept;
  logic [SLICE-1:0]   w_sel_hi;
  logic               w_sel_b;
  logic               w_ovf;
  logic [WIDTH-1:0]   w_wrap;
  logic [WIDTH-1:0]   w_diff_next;

  sub_slice #(.SLICE(SLICE)) u_lo (
    .a    (a[SLICE-1:0]),
    .b    (b[SLICE-1:0]),
    .bin  (1'b0),
    .d    (w_lo_d),
    .bout (w_lo_b)
  );

  // Index 0 assumes no borrow from the low slice, index 1 assumes one.
  for (genvar gi = 0; gi < 2; gi++) begin : g_hi
    sub_slice #(.SLICE(SLICE)) u_hi (
      .a    (a[WIDTH-1:SLICE]),
      .b    (b[WIDTH-1:SLICE]),
      .bin  (gi == 1),
      .d    (w_hi_d[gi]),
      .bout (w_hi_b[gi])
    );
  end

  assign w_s2_adv = !r_out_valid || out_ready;
  assign in_ready = !r_s1_valid || w_s2_adv;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_s1_valid <= 1'b0;
      r_lo       <= '0;
      r_bl       <= 1'b0;
      r_hi0      <= '0;
      r_hi1      <= '0;
      r_bh0      <= 1'b0;
      r_bh1      <= 1'b0;
      r_sa       <= 1'b0;
      r_sb       <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_lo       <= w_lo_d;
      r_bl       <= w_lo_b;
      r_hi0      <= w_hi_d[0];
      r_hi1      <= w_hi_d[1];
      r_bh0      <= w_hi_b[0];
      r_bh1      <= w_hi_b[1];
      r_sa       <= a[WIDTH-1];
      r_sb       <= b[WIDTH-1];
    end else if (w_s2_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  assign w_sel_hi = r_bl ? r_hi1 : r_hi0;
  assign w_sel_b  = r_bl ? r_bh1 : r_bh0;
  assign w_wrap   = {w_sel_hi, r_lo};
  assign w_ovf    = (r_sa != r_sb) && (w_sel_hi[SLICE-1] != r_sa);

`ifdef CSELSUB_SAT_EN
  // A negative minuend can only overflow downward, a non-negative one upward.
  assign w_diff_next = !w_ovf ? w_wrap
                     : (r_sa ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}});
`else
  assign w_diff_next = w_wrap;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_out_valid <= 1'b0;
      r_diff      <= '0;
      r_borrow    <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_diff     <= w_diff_next;
        r_borrow   <= w_sel_b;
        r_overflow <= w_ovf;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign diff      = r_diff;
  assign borrow    = r_borrow;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_cselsub_pipe.sv
// Self-checking bench for cselsub_pipe: directed scenarios plus random traffic
// against an arithmetic reference model (honours CSELSUB_SAT_EN).
module tb_cselsub_pipe;

  localparam int SLICE = 16;
  localparam int W     = 2 * SLICE;

  logic         clk       = 1'b0;
  logic         resetn    = 1'b0;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a         = '0;
  logic [W-1:0] b         = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] diff;
  logic         borrow;
  logic         overflow;

  cselsub_pipe #(.SLICE(SLICE)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        br;
    logic        ov;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
    exp_t   e;
    longint sx, sy, sd;
    sx   = longint'($signed(x));
    sy   = longint'($signed(y));
    sd   = sx - sy;
    e.d  = x - y;
    e.br = (x < y);
    e.ov = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
`ifdef CSELSUB_SAT_EN
    if (e.ov) e.d = (sd < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: drive at the falling edge, check/record handshakes, advance one cycle.
  task automatic cyc(input logic v, input logic [31:0] x, input logic [31:0] y,
                     input logic rdy, output logic acc);
    exp_t e;
    in_valid  = v;
    a         = x;
    b         = y;
    out_ready = rdy;
    #1;
    acc = v && in_ready;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", {31'b0, out_valid}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("diff", diff, e.d);
        chk("borrow", {31'b0, borrow}, {31'b0, e.br});
        chk("overflow", {31'b0, overflow}, {31'b0, e.ov});
        $display("out diff=%h borrow=%0b overflow=%0b", diff, borrow, overflow);
      end
    end
    if (acc) begin
      exp_q.push_back(model(x, y));
      $display("in  a=%h b=%h", x, y);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(output int n);
    logic acc;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      cyc(1'b0, 32'h0, 32'h0, 1'b1, acc);
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'h0);
  endtask

  task automatic single(input logic [31:0] x, input logic [31:0] y);
    logic acc;
    int   n;
    cyc(1'b1, x, y, 1'b1, acc);
    chk("single_accept", {31'b0, acc}, 32'h1);
    #1 chk("lat_cycle1_valid", {31'b0, out_valid}, 32'h0);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, acc);
    #1 chk("lat_cycle2_valid", {31'b0, out_valid}, 32'h1);
    drain(n);
    #1 chk("single_out_clear", {31'b0, out_valid}, 32'h0);
  endtask

  logic [31:0] sa_q[4];
  logic [31:0] sb_q[4];
  logic [31:0] hold_diff;
  logic        acc;
  int          idx;
  int          n;
  logic        pending;
  logic [31:0] pa, pb;

  initial begin
    // Reset state
    @(negedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_diff", diff, 32'h0);
    chk("rst_borrow", {31'b0, borrow}, 32'h0);
    chk("rst_overflow", {31'b0, overflow}, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
    @(negedge clk);
    resetn = 1'b1;

    // Directed operand cases
    single(32'h0001_0000, 32'h0000_0001);
    single(32'h0000_0000, 32'h0000_0001);
    single(32'h8000_0000, 32'h0000_0001);
    single(32'h7FFF_FFFF, 32'hFFFF_FFFF);
    single(32'h1234_5678, 32'h1234_5678);

    // Back-to-back: four operands, outputs on consecutive cycles
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, $urandom, $urandom, 1'b1, acc);
      chk("b2b_accept", {31'b0, acc}, 32'h1);
    end
    drain(n);
    chk("b2b_drain_cycles", 32'(n), 32'd2);

    // Back-to-back with a three-cycle downstream stall
    for (int i = 0; i < 4; i++) begin
      sa_q[i] = $urandom;
      sb_q[i] = $urandom;
    end
    idx = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, sa_q[idx], sb_q[idx], 1'b0, acc);
      if (acc) idx++;
      if (i == 1) hold_diff = diff;
    end
    #1;
    chk("stall_accepts", 32'(idx), 32'd2);
    chk("stall_in_ready", {31'b0, in_ready}, 32'h0);
    chk("stall_out_valid", {31'b0, out_valid}, 32'h1);
    chk("stall_diff_hold", diff, hold_diff);
    chk("stall_diff_value", diff, exp_q[0].d);
    for (int i = 0; i < 30; i++) begin
      if (idx == 4 && exp_q.size() == 0) break;
      if (idx < 4) cyc(1'b1, sa_q[idx], sb_q[idx], 1'b1, acc);
      else         cyc(1'b0, 32'h0, 32'h0, 1'b1, acc);
      if (acc) idx++;
    end
    chk("stall_all_accepted", 32'(idx), 32'd4);
    chk("stall_all_drained", 32'(exp_q.size()), 32'h0);

    // Asynchronous reset with two operations in flight
    cyc(1'b1, 32'hDEAD_BEEF, 32'h0000_1111, 1'b1, acc);
    cyc(1'b1, 32'hCAFE_0000, 32'h0000_0001, 1'b1, acc);
    in_valid = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk("arst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("arst_diff", diff, 32'h0);
    chk("arst_in_ready", {31'b0, in_ready}, 32'h1);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 32'h0, 32'h0, 1'b1, acc);
      #1 chk("post_rst_idle", {31'b0, out_valid}, 32'h0);
    end
    single(32'h0000_0005, 32'h0000_0007);

    // Random traffic with held operands and random backpressure
    pending = 1'b0;
    pa = '0;
    pb = '0;
    for (int i = 0; i < 300; i++) begin
      if (!pending && $urandom_range(0, 3) != 0) begin
        pa = $urandom;
        case ($urandom_range(0, 5))
          0:       pb = pa;
          1:       pb = pa ^ 32'h8000_0000;
          2:       pa = {1'b1, 31'($urandom)};
          default: ;
        endcase
        if (pb == pa && $urandom_range(0, 1) == 0) pb = $urandom;
        pending = 1'b1;
      end
      cyc(pending, pa, pb, $urandom_range(0, 2) != 0, acc);
      if (acc) begin
        pending = 1'b0;
        pb = $urandom;
      end
    end
    drain(n);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cselsub_pipe.md
Name: cselsub_pipe

Overview:
- Pipelined carry-select subtractor; the inverse operation of the team's carry-select adder.
- Computes diff = a - b at WIDTH = 2*SLICE bits.
- Low slice is subtracted directly. High slice is precomputed for borrow-in 0 and for borrow-in 1; the low-slice borrow-out selects between them one stage later.
- Sits on an ALU datapath behind a valid/ready handshake; full throughput of one operation per cycle.

Parameters:
- SLICE, 16, width of each subtract slice; total operand width is WIDTH = 2*SLICE.

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands this cycle
- a  input  2*SLICE  minuend
- b  input  2*SLICE  subtrahend
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- diff  output  2*SLICE  a - b, modulo 2^WIDTH
- borrow  output  1  unsigned borrow-out (1 when a < b unsigned)
- overflow  output  1  signed overflow: sign(a) != sign(b) and sign(diff) != sign(a)

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (resetn).
- Reset: s1_valid, out_valid, diff, borrow, overflow and all stage registers go to 0. in_ready is therefore 1 immediately after reset.
- Transfers:
  - Input accepted on a clk edge where in_valid && in_ready.
  - Output consumed on a clk edge where out_valid && out_ready.
- Stage 1 (registered on accept):
  - lo = a[SLICE-1:0] - b[SLICE-1:0] with borrow-in 0, kept with its borrow-out bl.
  - hi0 = a_hi - b_hi with borrow-in 0, kept with its borrow-out.
  - hi1 = a_hi - b_hi with borrow-in 1, kept with its borrow-out.
  - Sign bits of a and b are also registered.
- Stage 2 (registered):
  - diff = {bl ? hi1 : hi0, lo}.
  - borrow = borrow-out of the selected high slice.
  - overflow computed from the registered sign bits and diff's MSB.
- Advance rules:
  - s2_adv = !out_valid || out_ready.
  - Stage 1 moves into stage 2 when s1_valid && s2_adv.
  - in_ready = !s1_valid || s2_adv, combinational.
- Latency: exactly 2 cycles from accept to out_valid when there is no stall.
- Stall: while out_valid && !out_ready, diff/borrow/overflow hold stable. Stage 1 holds its contents; in_ready = 0 once stage 1 is full.
- Simultaneous events:
  - Output consume, stage-1 advance and new input accept all occur on the same edge; no bubble is inserted.
  - If stage 2 empties on an edge where stage 1 is empty, out_valid falls on that edge.
- in_valid while !in_ready: operands are ignored; the upstream holds them (standard valid/ready).
- Reset asserted mid-operation: all in-flight results are discarded and no partial output appears. After deassertion the first accept produces its result 2 cycles later.
- Arithmetic:
  - All slice subtraction is unsigned at SLICE+1 bits; wrap-around is modulo 2^WIDTH.
  - a == b gives diff = 0, borrow = 0, overflow = 0.

Optional Feature:
- Macro: CSELSUB_SAT_EN.
- Defined: on signed overflow, diff saturates at stage 2.
  - a negative (a - b overflowed below range): diff = 100..0 (most negative).
  - a non-negative: diff = 011..1 (most positive).
  - overflow and borrow report as without the macro.
- Undefined: diff always wraps modulo 2^WIDTH; no saturation logic is instantiated.

Decomposition:
- Package cselsub_pkg holds:
  - localparam SLICE_DEF = 16.
  - Typedef slice_res_t, a struct {logic bout; logic [SLICE-1:0] d}.
  - Constants SAT_POS and SAT_NEG.
- Sub-module sub_slice: SLICE-bit subtractor with inputs a, b, bin and outputs d, bout. Instantiated 3 times (lo, hi0, hi1).
- Top level holds the pipeline registers, select mux, flags, handshake and optional saturation.

Test Plan:
- a=0x00010000, b=0x00000001, out_ready=1 -> 2 cycles later diff=0x0000FFFF, borrow=0, overflow=0; the low borrow selects hi1.
- a=0x00000000, b=0x00000001 -> diff=0xFFFFFFFF, borrow=1, overflow=0.
- a=0x80000000, b=0x00000001 -> overflow=1, borrow=0. diff=0x7FFFFFFF without the macro; diff=0x80000000 with CSELSUB_SAT_EN.
- Back-to-back: 4 operands on consecutive cycles with out_ready=1 -> 4 consecutive out_valid cycles with correct results, in order.
- Back-to-back with stall: hold out_ready=0 for 3 cycles -> in_ready drops after 2 accepts and diff holds stable. On release the results drain in order with no loss or duplication.
- Drive resetn=0 asynchronously while 2 ops are in flight -> out_valid=0 and diff=0 immediately; no stale output after release. A new op after release yields its result 2 cycles later.
